// File: rtl/color_centroid_tracker.sv
// color_centroid_tracker
// Accumulates count, coordinate sums and bounding box of filter-matched pixels
// over one video frame. At each frame boundary it snapshots the totals and runs
// two restoring dividers to report the object centroid once per frame.
module color_centroid_tracker #(
    parameter int ACC_W      = 32,
    parameter int CNT_W      = 20,
    parameter int MIN_PIXELS = 64,
    parameter int MAX_ROW    = 477,
    parameter int MAX_COL    = 617
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             frame_start,
    input  logic [12:0]      row,
    input  logic [12:0]      col,
    input  logic             color_in,
    output logic [12:0]      centroid_row,
    output logic [12:0]      centroid_col,
    output logic [12:0]      box_row_min,
    output logic [12:0]      box_row_max,
    output logic [12:0]      box_col_min,
    output logic [12:0]      box_col_max,
    output logic [CNT_W-1:0] pixel_count,
    output logic             obj_found,
    output logic             result_valid,
    output logic             busy,
    output logic             frame_drop
);

    localparam int          ITER_W   = $clog2(ACC_W);
    localparam logic [12:0] MIN_INIT = 13'h1FFF;
    localparam logic [12:0] MAX_INIT = 13'h0000;

    typedef enum logic [1:0] {
        S_ACCUM  = 2'd0,
        S_DIVIDE = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t state_r, state_nx_s;

    // live per-frame accumulators
    logic [CNT_W-1:0] cnt_r;
    logic [ACC_W-1:0] sum_row_r, sum_col_r;
    logic [12:0]      row_min_r, row_max_r, col_min_r, col_max_r;

    // snapshot of the frame under division
    logic [CNT_W-1:0] snap_cnt_r;
    logic [12:0]      snap_row_min_r, snap_row_max_r, snap_col_min_r, snap_col_max_r;

    // divider state: dividend shifts out MSB-first while quotient bits shift in
    logic [ACC_W-1:0]  div_row_r, div_col_r;
    logic [ACC_W-1:0]  rem_row_r, rem_col_r;
    logic [ITER_W-1:0] iter_r;

    // registered outputs
    logic [12:0]      centroid_row_r, centroid_col_r;
    logic [12:0]      box_row_min_r, box_row_max_r, box_col_min_r, box_col_max_r;
    logic [CNT_W-1:0] pixel_count_r;
    logic             obj_found_r, result_valid_r, busy_r, frame_drop_r;

    logic             hit_s, found_s, last_iter_s;
    logic             report_found_s, report_empty_s, drop_s;
    logic [ACC_W-1:0] row_ext_s, col_ext_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [ACC_W:0]   dvs_ext_s, sh_row_s, sh_col_s;
    logic             ge_row_s, ge_col_s;

    assign hit_s       = pix_valid && color_in && (row <= 13'(MAX_ROW)) && (col <= 13'(MAX_COL));
    assign row_ext_s   = {{(ACC_W-13){1'b0}}, row};
    assign col_ext_s   = {{(ACC_W-13){1'b0}}, col};
    assign cnt_inc_s   = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : (cnt_r + CNT_W'(1));
    assign found_s     = (cnt_r >= CNT_W'(MIN_PIXELS));
    assign last_iter_s = (iter_r == ITER_W'(ACC_W - 1));

    // one restoring-division step for each coordinate
    assign dvs_ext_s = {{(ACC_W+1-CNT_W){1'b0}}, snap_cnt_r};
    assign sh_row_s  = {rem_row_r, div_row_r[ACC_W-1]};
    assign sh_col_s  = {rem_col_r, div_col_r[ACC_W-1]};
    assign ge_row_s  = (sh_row_s >= dvs_ext_s);
    assign ge_col_s  = (sh_col_s >= dvs_ext_s);

    // a new frame_start always wins over the last divide iteration
    assign drop_s         = (state_r == S_DIVIDE) && frame_start;
    assign report_found_s = (state_r == S_DIVIDE) && !frame_start && last_iter_s;
    assign report_empty_s = frame_start && !found_s;

    // Next-state logic; frame_start is handled identically from every state.
    always_comb begin
        state_nx_s = state_r;
        if (frame_start) begin
            if (found_s) begin
                state_nx_s = S_DIVIDE;
            end else begin
                state_nx_s = S_REPORT;
            end
        end else begin
            case (state_r)
                S_ACCUM: begin
                    state_nx_s = S_ACCUM;
                end
                S_DIVIDE: begin
                    if (last_iter_s) begin
                        state_nx_s = S_REPORT;
                    end else begin
                        state_nx_s = S_DIVIDE;
                    end
                end
                S_REPORT: begin
                    state_nx_s = S_ACCUM;
                end
                default: begin
                    state_nx_s = S_ACCUM;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_ACCUM;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Per-frame accumulation; a pixel arriving with frame_start opens the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            sum_row_r <= {ACC_W{1'b0}};
            sum_col_r <= {ACC_W{1'b0}};
            row_min_r <= MIN_INIT;
            row_max_r <= MAX_INIT;
            col_min_r <= MIN_INIT;
            col_max_r <= MAX_INIT;
        end else if (frame_start) begin
            if (hit_s) begin
                cnt_r     <= CNT_W'(1);
                sum_row_r <= row_ext_s;
                sum_col_r <= col_ext_s;
                row_min_r <= row;
                row_max_r <= row;
                col_min_r <= col;
                col_max_r <= col;
            end else begin
                cnt_r     <= {CNT_W{1'b0}};
                sum_row_r <= {ACC_W{1'b0}};
                sum_col_r <= {ACC_W{1'b0}};
                row_min_r <= MIN_INIT;
                row_max_r <= MAX_INIT;
                col_min_r <= MIN_INIT;
                col_max_r <= MAX_INIT;
            end
        end else if (hit_s) begin
            cnt_r     <= cnt_inc_s;
            sum_row_r <= sum_row_r + row_ext_s;
            sum_col_r <= sum_col_r + col_ext_s;
            if (row < row_min_r) row_min_r <= row;
            if (row > row_max_r) row_max_r <= row;
            if (col < col_min_r) col_min_r <= col;
            if (col > col_max_r) col_max_r <= col;
        end
    end

    // Snapshot and divider: load on a reportable frame_start, else iterate while dividing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_cnt_r     <= {CNT_W{1'b0}};
            snap_row_min_r <= 13'h0000;
            snap_row_max_r <= 13'h0000;
            snap_col_min_r <= 13'h0000;
            snap_col_max_r <= 13'h0000;
            div_row_r      <= {ACC_W{1'b0}};
            div_col_r      <= {ACC_W{1'b0}};
            rem_row_r      <= {ACC_W{1'b0}};
            rem_col_r      <= {ACC_W{1'b0}};
            iter_r         <= {ITER_W{1'b0}};
        end else if (frame_start && found_s) begin
            snap_cnt_r     <= cnt_r;
            snap_row_min_r <= row_min_r;
            snap_row_max_r <= row_max_r;
            snap_col_min_r <= col_min_r;
            snap_col_max_r <= col_max_r;
            div_row_r      <= sum_row_r;
            div_col_r      <= sum_col_r;
            rem_row_r      <= {ACC_W{1'b0}};
            rem_col_r      <= {ACC_W{1'b0}};
            iter_r         <= {ITER_W{1'b0}};
        end else if (state_r == S_DIVIDE) begin
            div_row_r <= {div_row_r[ACC_W-2:0], ge_row_s};
            div_col_r <= {div_col_r[ACC_W-2:0], ge_col_s};
            rem_row_r <= ACC_W'(ge_row_s ? (sh_row_s - dvs_ext_s) : sh_row_s);
            rem_col_r <= ACC_W'(ge_col_s ? (sh_col_s - dvs_ext_s) : sh_col_s);
            iter_r    <= iter_r + ITER_W'(1);
        end
    end

    // Output registers; the cycle these load is the REPORT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            centroid_row_r <= 13'h0000;
            centroid_col_r <= 13'h0000;
            box_row_min_r  <= 13'h0000;
            box_row_max_r  <= 13'h0000;
            box_col_min_r  <= 13'h0000;
            box_col_max_r  <= 13'h0000;
            pixel_count_r  <= {CNT_W{1'b0}};
            obj_found_r    <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            frame_drop_r   <= 1'b0;
        end else begin
            result_valid_r <= report_found_s || report_empty_s;
            frame_drop_r   <= drop_s;
            busy_r         <= (state_nx_s == S_DIVIDE);
            if (report_found_s) begin
                centroid_row_r <= {div_row_r[11:0], ge_row_s};
                centroid_col_r <= {div_col_r[11:0], ge_col_s};
                box_row_min_r  <= snap_row_min_r;
                box_row_max_r  <= snap_row_max_r;
                box_col_min_r  <= snap_col_min_r;
                box_col_max_r  <= snap_col_max_r;
                pixel_count_r  <= snap_cnt_r;
                obj_found_r    <= 1'b1;
            end else if (report_empty_s) begin
                pixel_count_r  <= cnt_r;
                obj_found_r    <= 1'b0;
            end
        end
    end

    assign centroid_row = centroid_row_r;
    assign centroid_col = centroid_col_r;
    assign box_row_min  = box_row_min_r;
    assign box_row_max  = box_row_max_r;
    assign box_col_min  = box_col_min_r;
    assign box_col_max  = box_col_max_r;
    assign pixel_count  = pixel_count_r;
    assign obj_found    = obj_found_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;
    assign frame_drop   = frame_drop_r;

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Bench for color_centroid_tracker: two instances (MIN_PIXELS=1 and default 64)
// share one stimulus stream; a frame model pushes expected reports to per-instance
// queues, which a negedge monitor pops when result_valid pulses.
module tb_color_centroid_tracker;

    logic        clk = 1'b0;
    logic        rst_n, pix_valid, frame_start, color_in;
    logic [12:0] row, col;

    logic [12:0] crow [2];
    logic [12:0] ccol [2];
    logic [12:0] rmin [2];
    logic [12:0] rmax [2];
    logic [12:0] cmin [2];
    logic [12:0] cmax [2];
    logic [19:0] pcnt [2];
    logic        fnd  [2];
    logic        rv   [2];
    logic        bsy  [2];
    logic        drp  [2];

    color_centroid_tracker #(.MIN_PIXELS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .frame_start(frame_start),
        .row(row), .col(col), .color_in(color_in),
        .centroid_row(crow[0]), .centroid_col(ccol[0]),
        .box_row_min(rmin[0]), .box_row_max(rmax[0]),
        .box_col_min(cmin[0]), .box_col_max(cmax[0]),
        .pixel_count(pcnt[0]), .obj_found(fnd[0]), .result_valid(rv[0]),
        .busy(bsy[0]), .frame_drop(drp[0])
    );

    color_centroid_tracker dut_b (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .frame_start(frame_start),
        .row(row), .col(col), .color_in(color_in),
        .centroid_row(crow[1]), .centroid_col(ccol[1]),
        .box_row_min(rmin[1]), .box_row_max(rmax[1]),
        .box_col_min(cmin[1]), .box_col_max(cmax[1]),
        .pixel_count(pcnt[1]), .obj_found(fnd[1]), .result_valid(rv[1]),
        .busy(bsy[1]), .frame_drop(drp[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        int fs_cyc;
        bit found;
        int cnt;
        int crow;
        int ccol;
        int rmin;
        int rmax;
        int cmin;
        int cmax;
    } exp_t;

    exp_t q [2][$];
    exp_t last [2];

    int tests, fails, cyc;
    int exp_drop [2];
    int seen_drop [2];
    int m_cnt, m_srow, m_scol, m_rmin, m_rmax, m_cmin, m_cmax;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int minp(input int i);
        return (i == 0) ? 1 : 64;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_srow = 0; m_scol = 0;
        m_rmin = 8191; m_rmax = 0; m_cmin = 8191; m_cmax = 0;
    endtask

    // drive one clock of input; frame_start closes the model frame first
    task automatic tick(input bit v, input bit fs, input int r, input int c, input bit ci);
        pix_valid   = v;
        frame_start = fs;
        row         = 13'(r);
        col         = 13'(c);
        color_in    = ci;
        if (fs) begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                if (q[i].size() > 0) begin
                    if (q[i][q[i].size()-1].found && (cyc - q[i][q[i].size()-1].fs_cyc) <= 32) begin
                        void'(q[i].pop_back());
                        exp_drop[i]++;
                    end
                end
                e.fs_cyc = cyc;
                e.found  = (m_cnt >= minp(i));
                e.cnt    = m_cnt;
                e.crow   = (m_cnt > 0) ? (m_srow / m_cnt) : 0;
                e.ccol   = (m_cnt > 0) ? (m_scol / m_cnt) : 0;
                e.rmin   = m_rmin; e.rmax = m_rmax;
                e.cmin   = m_cmin; e.cmax = m_cmax;
                q[i].push_back(e);
            end
            model_clear();
        end
        if (v && ci && r <= 477 && c <= 617) begin
            m_cnt++; m_srow += r; m_scol += c;
            if (r < m_rmin) m_rmin = r;
            if (r > m_rmax) m_rmax = r;
            if (c < m_cmin) m_cmin = c;
            if (c > m_cmax) m_cmax = c;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic zero_check(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_dut%0d_flags", tag, i), 32'({rv[i], bsy[i], drp[i], fnd[i]}), 32'd0);
            check($sformatf("%s_dut%0d_coords", tag, i),
                  32'(crow[i] | ccol[i] | rmin[i] | rmax[i] | cmin[i] | cmax[i]), 32'd0);
            check($sformatf("%s_dut%0d_count", tag, i), 32'(pcnt[i]), 32'd0);
        end
    endtask

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (drp[i] === 1'b1) seen_drop[i]++;
            if (rv[i] === 1'b1) begin
                check($sformatf("dut%0d_result_expected", i), 32'(q[i].size() > 0), 32'd1);
                if (q[i].size() > 0) begin
                    exp_t e;
                    e = q[i].pop_front();
                    check($sformatf("dut%0d_latency", i), 32'(cyc - e.fs_cyc), e.found ? 32'd33 : 32'd1);
                    check($sformatf("dut%0d_obj_found", i), 32'(fnd[i]), 32'(e.found));
                    check($sformatf("dut%0d_pixel_count", i), 32'(pcnt[i]), 32'(e.cnt));
                    if (e.found) begin
                        last[i].crow = e.crow; last[i].ccol = e.ccol;
                        last[i].rmin = e.rmin; last[i].rmax = e.rmax;
                        last[i].cmin = e.cmin; last[i].cmax = e.cmax;
                    end
                    check($sformatf("dut%0d_centroid_row", i), 32'(crow[i]), 32'(last[i].crow));
                    check($sformatf("dut%0d_centroid_col", i), 32'(ccol[i]), 32'(last[i].ccol));
                    check($sformatf("dut%0d_box_row_min", i), 32'(rmin[i]), 32'(last[i].rmin));
                    check($sformatf("dut%0d_box_row_max", i), 32'(rmax[i]), 32'(last[i].rmax));
                    check($sformatf("dut%0d_box_col_min", i), 32'(cmin[i]), 32'(last[i].cmin));
                    check($sformatf("dut%0d_box_col_max", i), 32'(cmax[i]), 32'(last[i].cmax));
                end
            end
        end
    end

    initial begin
        tests = 0; fails = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            exp_drop[i] = 0; seen_drop[i] = 0;
            last[i] = '{default: 0};
        end
        model_clear();
        rst_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
        row = 13'd0; col = 13'd0; color_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        zero_check("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // empty frame: nothing to report for either threshold
        tick(1'b0, 1'b1, 0, 0, 1'b0);
        idle(5);

        // single match at (100,200)
        tick(1'b1, 1'b0, 100, 200, 1'b1);
        tick(1'b0, 1'b1, 0, 0, 1'b0);
        check("dut0_busy_after_fs", 32'(bsy[0]), 32'd1);
        check("dut1_busy_after_fs", 32'(bsy[1]), 32'd0);
        idle(40);

        // 10x10 block rows 50..59 cols 300..309
        for (int r = 50; r < 60; r++)
            for (int c = 300; c < 310; c++)
                tick(1'b1, 1'b0, r, c, 1'b1);
        tick(1'b0, 1'b1, 0, 0, 1'b0);
        idle(40);

        // 30 matches: reported by dut0 only, dut1 holds previous result
        for (int c = 20; c < 50; c++) tick(1'b1, 1'b0, 10, c, 1'b1);
        tick(1'b0, 1'b1, 0, 0, 1'b0);
        idle(40);

        // out-of-window and non-valid pixels are ignored
        tick(1'b1, 1'b0, 478, 5, 1'b1);
        tick(1'b1, 1'b0, 5, 618, 1'b1);
        tick(1'b0, 1'b0, 5, 5, 1'b1);
        tick(1'b1, 1'b0, 6, 6, 1'b0);
        tick(1'b0, 1'b1, 0, 0, 1'b0);
        idle(5);

        // window corners are accepted
        tick(1'b1, 1'b0, 477, 617, 1'b1);
        tick(1'b1, 1'b0, 0, 0, 1'b1);
        tick(1'b0, 1'b1, 0, 0, 1'b0);
        idle(40);

        // abort: second frame_start 10 cycles into the divide, carrying a pixel
        for (int r = 200; r < 210; r++)
            for (int c = 400; c < 410; c++)
                tick(1'b1, 1'b0, r, c, 1'b1);
        tick(1'b0, 1'b1, 0, 0, 1'b0);
        for (int c = 100; c < 109; c++) tick(1'b1, 1'b0, 300, c, 1'b1);
        tick(1'b1, 1'b1, 300, 110, 1'b1);
        idle(40);

        // reset in the middle of a divide
        for (int r = 20; r < 30; r++)
            for (int c = 30; c < 40; c++)
                tick(1'b1, 1'b0, r, c, 1'b1);
        tick(1'b0, 1'b1, 0, 0, 1'b0);
        idle(5);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            last[i] = '{default: 0};
        end
        model_clear();
        #1;
        zero_check("midreset");
        @(posedge clk);
        @(posedge clk);
        #1;
        zero_check("heldreset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full frame after reset, exactly 64 pixels
        for (int r = 400; r < 408; r++)
            for (int c = 500; c < 508; c++)
                tick(1'b1, 1'b0, r, c, 1'b1);
        tick(1'b0, 1'b1, 0, 0, 1'b0);
        idle(40);

        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_pending_results", i), 32'(q[i].size()), 32'd0);
            check($sformatf("dut%0d_frame_drop_count", i), 32'(seen_drop[i]), 32'(exp_drop[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/color_centroid_tracker.md
Name: color_centroid_tracker

Overview:
- Sits directly downstream of the per-pixel HSV colour filter and consumes its o_color flag together with the pixel's row/col coordinates.
- Accumulates matching-pixel count, coordinate sums and bounding box over one video frame.
- At each frame boundary it snapshots the totals and runs an iterative divider to produce the object centroid.
- The pong game logic uses the centroid as the paddle position, updated once per frame.

Parameters:
- ACC_W, 32, width of the coordinate-sum accumulators and the divider dividend.
- CNT_W, 20, width of the pixel counter (supports 640x480 = 307200 pixels).
- MIN_PIXELS, 64, minimum matching-pixel count for a frame to report an object (noise reject).
- MAX_ROW, 477, last row accepted; matches the filter's active window.
- MAX_COL, 617, last col accepted; matches the filter's active window.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  current row/col/color_in are a real pixel this cycle.
- frame_start  in  1  one-cycle pulse marking the start of a new frame.
- row  in  13  pixel row.
- col  in  13  pixel column.
- color_in  in  1  filter match flag (o_color of the filter).
- centroid_row  out  13  floor(sum_row/count) of the last reported frame.
- centroid_col  out  13  floor(sum_col/count) of the last reported frame.
- box_row_min  out  13  bounding-box top of the last reported frame.
- box_row_max  out  13  bounding-box bottom.
- box_col_min  out  13  bounding-box left.
- box_col_max  out  13  bounding-box right.
- pixel_count  out  CNT_W  matching pixels in the last completed frame.
- obj_found  out  1  last completed frame had pixel_count >= MIN_PIXELS.
- result_valid  out  1  one-cycle pulse when the outputs update.
- busy  out  1  divider running.
- frame_drop  out  1  one-cycle pulse when a division is aborted.

Behaviour:
- Reset (async assert, sync release): all outputs 0; accumulators cleared; row_min/col_min = 13'h1FFF; row_max/col_max = 0; FSM to ACCUM.
- Accumulate condition: pix_valid && color_in && row <= MAX_ROW && col <= MAX_COL. When true: count += 1, sum_row += row, sum_col += col (zero-extended to ACC_W), and the min/max registers update.
- Counter saturation: count saturates at all-ones; the sums never overflow within a 640x480 frame at ACC_W = 32.
- frame_start cycle:
  - Snapshot count, sums and box into shadow registers.
  - Clear the accumulators to their reset values.
  - If pix_valid is also high that cycle, the pixel is the first pixel of the new frame: it is excluded from the snapshot and accumulated into the cleared accumulators.
- FSM states:
  - ACCUM: idle divider. On frame_start, go to DIVIDE if snapshot count >= MIN_PIXELS, else go to REPORT.
  - DIVIDE: two parallel restoring dividers (sum_row/count and sum_col/count), one quotient bit per cycle, MSB first, exactly ACC_W cycles. Then go to REPORT.
  - REPORT: single cycle, then back to ACCUM.
- busy is high exactly while in DIVIDE.
- REPORT cycle actions:
  - Pulse result_valid.
  - Load pixel_count, box_*, obj_found.
  - If the object was found, load centroid_* from the low 13 quotient bits.
  - If not found, centroid_* and box_* hold their previous values; obj_found = 0; pixel_count is still updated.
- Latency: frame_start sampled at cycle 0 → result_valid at cycle ACC_W+1 (33) if the object was found, at cycle 1 if not.
- Accumulation continues normally during DIVIDE and REPORT.
- frame_start while in DIVIDE: abort the current division; pulse frame_drop; take the new snapshot; restart DIVIDE at iteration 0, or go to REPORT if below MIN_PIXELS. No result_valid is issued for the aborted frame.
- frame_start in REPORT: REPORT completes; the new snapshot is processed starting next cycle, with the same latency as from ACCUM.
- Divide by zero cannot occur, since MIN_PIXELS >= 1 is required.
- rst_n low mid-DIVIDE: immediate return to reset state; no result_valid, no frame_drop.

Test Plan:
- MIN_PIXELS=1; frame with a single match at (100,200); then frame_start → result_valid at cycle 33; centroid=(100,200); count=1; box=100..100 / 200..200; obj_found=1.
- 10x10 block, rows 50..59, cols 300..309 → count=100, sum_row=5450, centroid_row=54, centroid_col=304, box 50..59 / 300..309.
- Frame with 30 matches (MIN_PIXELS=64) → result_valid at cycle 1; obj_found=0; pixel_count=30; centroid/box unchanged from the previous frame.
- Matches at row 478 or col 618 with color_in=1 → ignored, count=0. pix_valid=0 with color_in=1 → ignored.
- frame_start asserted 10 cycles into DIVIDE → frame_drop pulse; only one result_valid, 33 cycles after the second frame_start, carrying the second frame's data.
- rst_n pulsed low at DIVIDE iteration 5 → all outputs 0 during reset; no result_valid; the next full frame reports correctly.
